// File: rtl/frame_update_sequencer.sv
// frame_update_sequencer
// Once per video frame, walks the update units in a fixed order
// (input latch -> physics -> collision -> scroll -> commit) using start/done
// handshakes. Owns the MENU/PLAY/OVER game state, counts frames dropped while
// busy, and flags any stage that had to be forced on by the timeout.
module frame_update_sequencer #(
    parameter int unsigned SCROLL_LINE = 200,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned OVR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_sync,
    input  logic             button_left,
    input  logic             button_right,
    input  logic             doodle_fell,
    input  logic [9:0]       doodle_y,
    output logic             phys_start,
    input  logic             phys_done,
    output logic             coll_start,
    input  logic             coll_done,
    output logic             scroll_start,
    input  logic             scroll_done,
    output logic [9:0]       scroll_amount,
    output logic             commit,
    output logic [1:0]       buttons_q,
    output logic [1:0]       game_state,
    output logic             busy,
    output logic [OVR_W-1:0] overrun_count,
    output logic             timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_PHYS   = 3'd2;
    localparam logic [2:0] S_COLL   = 3'd3;
    localparam logic [2:0] S_SCROLL = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    localparam logic [1:0] GS_MENU = 2'd0;
    localparam logic [1:0] GS_PLAY = 2'd1;
    localparam logic [1:0] GS_OVER = 2'd2;

    localparam int unsigned   CW            = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST       = CW'(TIMEOUT - 1);
    localparam logic [9:0]    SCROLL_LINE_Y = 10'(SCROLL_LINE);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fs_q;
    logic [9:0]       amt_q, amt_d;
    logic [1:0]       btn_q, btn_d;
    logic [1:0]       gs_q, gs_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             terr_q, terr_d;

    logic tick;
    logic waiting;
    logic stage_done;
    logic timed_out;
    logic advance;

    // New frame starts on the falling edge of frame_sync
    assign tick = fs_q & ~frame_sync;

    // Select the done input for the stage being waited on and qualify the timeout
    always_comb begin
        waiting    = 1'b0;
        stage_done = 1'b0;
        case (state_q)
            S_PHYS:   begin waiting = 1'b1; stage_done = phys_done;   end
            S_COLL:   begin waiting = 1'b1; stage_done = coll_done;   end
            S_SCROLL: begin waiting = 1'b1; stage_done = scroll_done; end
            default:  begin end
        endcase
        timed_out = waiting & (cnt_q == TO_LAST);
        advance   = stage_done | timed_out;
    end

    // Sequencer next state, latched frame data, game state and error tracking
    always_comb begin
        state_d = state_q;
        amt_d   = amt_q;
        btn_d   = btn_q;
        gs_d    = gs_q;
        terr_d  = terr_q;
        ovr_d   = ovr_q;
        cnt_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_LATCH;
            end
            S_LATCH: begin
                btn_d   = {button_left, button_right};
                state_d = (gs_q == GS_PLAY) ? S_PHYS : S_COMMIT;
            end
            S_PHYS: begin
                if (advance) state_d = S_COLL;
            end
            S_COLL: begin
                if (advance) begin
                    if (doodle_y < SCROLL_LINE_Y) begin
                        amt_d   = SCROLL_LINE_Y - doodle_y;
                        state_d = S_SCROLL;
                    end else begin
                        amt_d   = '0;
                        state_d = S_COMMIT;
                    end
                end
            end
            S_SCROLL: begin
                if (advance) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                case (gs_q)
                    GS_MENU: if (btn_q == 2'b11) gs_d = GS_PLAY;
                    GS_PLAY: if (doodle_fell)    gs_d = GS_OVER;
                    GS_OVER: if (btn_q == 2'b11) gs_d = GS_MENU;
                    default: gs_d = GS_MENU;
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A done arriving on the last allowed cycle wins over the timeout
        if (timed_out && !stage_done) terr_d = 1'b1;

        // COMMIT is still busy, so a tick on the return-to-IDLE cycle is dropped too
        if (tick && (state_q != S_IDLE) && (ovr_q != '1)) ovr_d = ovr_q + 1'b1;

        // Counter is zero on the entry cycle of each wait stage, which also marks the start pulse
        if (waiting && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fs_q    <= 1'b1;
            amt_q   <= '0;
            btn_q   <= '0;
            gs_q    <= GS_MENU;
            ovr_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fs_q    <= frame_sync;
            amt_q   <= amt_d;
            btn_q   <= btn_d;
            gs_q    <= gs_d;
            ovr_q   <= ovr_d;
            terr_q  <= terr_d;
        end
    end

    assign phys_start    = (state_q == S_PHYS)   && (cnt_q == '0);
    assign coll_start    = (state_q == S_COLL)   && (cnt_q == '0);
    assign scroll_start  = (state_q == S_SCROLL) && (cnt_q == '0);
    assign commit        = (state_q == S_COMMIT);
    assign busy          = (state_q != S_IDLE);
    assign scroll_amount = amt_q;
    assign buttons_q     = btn_q;
    assign game_state    = gs_q;
    assign overrun_count = ovr_q;
    assign timeout_err   = terr_q;

endmodule
